// File: rtl/sme_pkg.sv
// rtl/sme_pkg.sv - shared types and constants for the SME record feeder
package sme_pkg;

  // Feeder control states: accept first beat, accept rest, replay burst, await SME result
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_OVF     = 2'd1;
  localparam logic [1:0] ERR_NOSTR   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam int STR_MAX = 32;
  localparam int PAT_MAX = 8;
  localparam int IDX_W   = $clog2(STR_MAX);

endpackage

// File: rtl/sme_char_buf.sv
// rtl/sme_char_buf.sv - record byte buffer with registered, write-through read
module sme_char_buf
  import sme_pkg::*;
#(
  parameter int DEPTH = STR_MAX,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_we,
  input  logic [AW-1:0] i_wr_ptr,
  input  logic [7:0]    i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_ptr,
  output logic [7:0]    o_rd_data
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rd_data;

  // Store accepted bytes; contents need no reset since every read follows a write
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wr_ptr] <= i_wr_data;
    end
  end

  // Read register doubles as the SME char output, so it only moves on i_rd_en and
  // forwards a same-cycle write (single-byte record read on its own last beat)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data <= 8'd0;
    end else if (i_rd_en) begin
      r_rd_data <= (i_we && (i_wr_ptr == i_rd_ptr)) ? i_wr_data : r_mem[i_rd_ptr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sme_rec_feeder.sv
// rtl/sme_rec_feeder.sv - buffers string/pattern records and replays them to SME
module sme_rec_feeder
  import sme_pkg::*;
#(
  parameter int STR_MAX = sme_pkg::STR_MAX,
  parameter int PAT_MAX = sme_pkg::PAT_MAX,
  parameter int TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_kind,
  input  logic       in_last,
  output logic [7:0] sme_chardata,
  output logic       sme_isstring,
  output logic       sme_ispattern,
  input  logic       sme_valid,
  input  logic       sme_match,
  input  logic [4:0] sme_match_index,
  output logic       res_valid,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       err_valid,
  output logic [1:0] err_code
);

  localparam int AW = $clog2(STR_MAX);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        r_state, w_next;
  logic          r_has_string, r_kind, r_ovf;
  logic [CW-1:0] r_wr_ptr, r_len, r_send_idx;
  logic [TW-1:0] r_timer;
  logic          r_isstring, r_ispattern;
  logic          r_res_valid, r_res_match;
  logic [4:0]    r_res_index;
  logic          r_err_valid;
  logic [1:0]    r_err_code;

  logic          w_load, w_beat, w_kind, w_room, w_nostr, w_start, w_more, w_we, w_rd_en;
  logic          w_timeout;
  logic [CW-1:0] w_limit, w_len;
  logic [AW-1:0] w_rd_ptr;
  logic [7:0]    w_rd_data;

  // Next-state and per-cycle control decode
  always_comb begin
    w_next    = r_state;
    w_load    = (r_state == ST_IDLE) || (r_state == ST_LOAD);
    w_beat    = in_valid && w_load;
    w_kind    = (r_state == ST_IDLE) ? in_kind : r_kind;
    w_limit   = w_kind ? CW'(PAT_MAX) : CW'(STR_MAX);
    w_room    = r_wr_ptr < w_limit;
    w_we      = w_beat && w_room;
    w_len     = w_room ? r_wr_ptr + CW'(1) : r_wr_ptr;
    w_nostr   = w_kind && !r_has_string;
    w_start   = w_beat && in_last && !w_nostr;
    w_more    = (r_state == ST_SEND) && ((r_send_idx + CW'(1)) < r_len);
    w_rd_en   = w_start || w_more;
    w_rd_ptr  = w_start ? AW'(0) : AW'(r_send_idx + CW'(1));
    w_timeout = r_timer == TW'(TIMEOUT - 1);
    unique case (r_state)
      ST_IDLE, ST_LOAD: begin
        if (w_beat) begin
          if (in_last) w_next = w_nostr ? ST_IDLE : ST_SEND;
          else         w_next = ST_LOAD;
        end
      end
      ST_SEND: if (!w_more) w_next = r_kind ? ST_WAIT : ST_IDLE;
      ST_WAIT: if (sme_valid || w_timeout) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Record counters, burst strobes, WAIT timer and result/error pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      r_has_string <= 1'b0;
      r_kind       <= 1'b0;
      r_ovf        <= 1'b0;
      r_wr_ptr     <= '0;
      r_len        <= '0;
      r_send_idx   <= '0;
      r_timer      <= '0;
      r_isstring   <= 1'b0;
      r_ispattern  <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_match  <= 1'b0;
      r_res_index  <= '0;
      r_err_valid  <= 1'b0;
      r_err_code   <= ERR_NONE;
    end else begin
      r_res_valid <= 1'b0;
      r_err_valid <= 1'b0;
      r_err_code  <= ERR_NONE;
      unique case (r_state)
        ST_IDLE, ST_LOAD: begin
          if (w_beat) begin
            r_kind <= w_kind;
            if (w_we) r_wr_ptr <= r_wr_ptr + CW'(1);
            if (!w_room) r_ovf <= 1'b1;
            if (in_last) begin
              r_wr_ptr   <= '0;
              r_len      <= w_len;
              r_send_idx <= '0;
              if (w_nostr) begin
                r_ovf       <= 1'b0;
                r_err_valid <= 1'b1;
                r_err_code  <= ERR_NOSTR;
              end else begin
                r_isstring  <= !w_kind;
                r_ispattern <= w_kind;
              end
            end
          end
        end
        ST_SEND: begin
          if (w_more) begin
            r_send_idx <= r_send_idx + CW'(1);
          end else begin
            r_isstring  <= 1'b0;
            r_ispattern <= 1'b0;
            r_ovf       <= 1'b0;
            r_timer     <= '0;
            if (!r_kind) r_has_string <= 1'b1;
            if (r_ovf) begin
              r_err_valid <= 1'b1;
              r_err_code  <= ERR_OVF;
            end
          end
        end
        ST_WAIT: begin
          if (sme_valid) begin
            r_res_valid <= 1'b1;
            r_res_match <= sme_match;
            r_res_index <= sme_match_index;
          end else if (w_timeout) begin
            r_err_valid <= 1'b1;
            r_err_code  <= ERR_TIMEOUT;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  sme_char_buf #(.DEPTH(STR_MAX), .AW(AW)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .i_we      (w_we),
    .i_wr_ptr  (r_wr_ptr[AW-1:0]),
    .i_wr_data (in_data),
    .i_rd_en   (w_rd_en),
    .i_rd_ptr  (w_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  assign in_ready      = w_load && !reset;
  assign sme_chardata  = w_rd_data;
  assign sme_isstring  = r_isstring;
  assign sme_ispattern = r_ispattern;
  assign res_valid     = r_res_valid;
  assign res_match     = r_res_match;
  assign res_index     = r_res_index;
  assign err_valid     = r_err_valid;
  assign err_code      = r_err_code;

endmodule

// File: tb/tb_sme_rec_feeder.sv
// tb/tb_sme_rec_feeder.sv - directed self-checking bench for sme_rec_feeder
module tb_sme_rec_feeder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'd0;
  logic       in_kind = 1'b0;
  logic       in_last = 1'b0;
  logic [7:0] sme_chardata;
  logic       sme_isstring, sme_ispattern;
  logic       sme_valid = 1'b0;
  logic       sme_match = 1'b0;
  logic [4:0] sme_match_index = 5'd0;
  logic       res_valid, res_match;
  logic [4:0] res_index;
  logic       err_valid;
  logic [1:0] err_code;

  sme_rec_feeder #(.STR_MAX(32), .PAT_MAX(8), .TIMEOUT(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .in_kind         (in_kind),
    .in_last         (in_last),
    .sme_chardata    (sme_chardata),
    .sme_isstring    (sme_isstring),
    .sme_ispattern   (sme_ispattern),
    .sme_valid       (sme_valid),
    .sme_match       (sme_match),
    .sme_match_index (sme_match_index),
    .res_valid       (res_valid),
    .res_match       (res_match),
    .res_index       (res_index),
    .err_valid       (err_valid),
    .err_code        (err_code)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [7:0] ch; logic pat; } ch_ev_t;
  typedef struct { int cyc; logic [1:0] code; } err_ev_t;
  typedef struct { int cyc; logic match; logic [4:0] idx; } res_ev_t;

  ch_ev_t  chq[$];
  err_ev_t errq[$];
  res_ev_t resq[$];
  int cyc = 0;
  int both_high = 0;
  int checks = 0;
  int failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every SME strobe and every result/error pulse with its cycle stamp
  always @(negedge clk) begin
    ch_ev_t c;
    err_ev_t e;
    res_ev_t r;
    if (sme_isstring || sme_ispattern) begin
      c.cyc = cyc; c.ch = sme_chardata; c.pat = sme_ispattern;
      chq.push_back(c);
    end
    if (sme_isstring && sme_ispattern) both_high++;
    if (err_valid) begin
      e.cyc = cyc; e.code = err_code;
      errq.push_back(e);
    end
    if (res_valid) begin
      r.cyc = cyc; r.match = res_match; r.idx = res_index;
      resq.push_back(r);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_rec(input string s, input logic k, input bit stall, output int last_cyc);
    for (int i = 0; i < s.len(); i++) begin
      int n;
      if (stall && i > 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = s[i];
      in_kind  = k;
      in_last  = (i == s.len() - 1);
      n = 0;
      #1;
      while (!in_ready && n < 100) begin
        @(negedge clk);
        #1;
        n++;
      end
      if (n >= 100) chk("in_ready_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    last_cyc = cyc;
  endtask

  task automatic check_burst(input string tag, input string exp, input logic pat, input int start);
    chk({tag, "_len"}, 32'(chq.size()), 32'(exp.len()));
    for (int i = 0; i < exp.len() && i < chq.size(); i++) begin
      chk({tag, "_ch"}, 32'(chq[i].ch), 32'(exp[i]));
      chk({tag, "_kind"}, 32'(chq[i].pat), 32'(pat));
      chk({tag, "_cyc"}, 32'(chq[i].cyc), 32'(start + i));
    end
    chq.delete();
  endtask

  task automatic check_err(input string tag, input int n, input logic [1:0] code, input int at);
    chk({tag, "_errcnt"}, 32'(errq.size()), 32'(n));
    if (n > 0 && errq.size() > 0) begin
      chk({tag, "_errcode"}, 32'(errq[0].code), 32'(code));
      chk({tag, "_errcyc"}, 32'(errq[0].cyc), 32'(at));
    end
    errq.delete();
  endtask

  task automatic check_res(input string tag, input int n, input logic m, input logic [4:0] idx, input int at);
    chk({tag, "_rescnt"}, 32'(resq.size()), 32'(n));
    if (n > 0 && resq.size() > 0) begin
      chk({tag, "_resmatch"}, 32'(resq[0].match), 32'(m));
      chk({tag, "_residx"}, 32'(resq[0].idx), 32'(idx));
      chk({tag, "_rescyc"}, 32'(resq[0].cyc), 32'(at));
    end
    resq.delete();
  endtask

  task automatic sme_reply(input int wait_n, input logic m, input logic [4:0] idx);
    repeat (wait_n) @(negedge clk);
    sme_valid = 1'b1; sme_match = m; sme_match_index = idx;
    @(negedge clk);
    sme_valid = 1'b0; sme_match = 1'b0; sme_match_index = 5'd0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_chardata"}, 32'(sme_chardata), 32'd0);
    chk({tag, "_isstring"}, 32'(sme_isstring), 32'd0);
    chk({tag, "_ispattern"}, 32'(sme_ispattern), 32'd0);
    chk({tag, "_res"}, {res_valid, res_match, res_index}, 32'd0);
    chk({tag, "_err"}, {err_valid, err_code}, 32'd0);
  endtask

  initial begin
    int k0;
    string s40;
    s40 = "0123456789ABCDEFGHIJKLMNOPQRSTUVWXYZabcd";

    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    #1;
    chk("post_reset_ready", 32'(in_ready), 32'd1);
    chq.delete(); errq.delete(); resq.delete();

    // Pattern before any string: error 2, nothing to SME
    send_rec("ab", 1'b1, 1'b0, k0);
    repeat (3) @(negedge clk);
    check_burst("nostr", "", 1'b1, k0);
    check_err("nostr", 1, 2'd2, k0);

    // String "abcde"
    send_rec("abcde", 1'b0, 1'b0, k0);
    repeat (7) @(negedge clk);
    check_burst("str5", "abcde", 1'b0, k0);
    check_err("str5", 0, 2'd0, 0);
    check_res("str5", 0, 1'b0, 5'd0, 0);

    // Pattern "cd" with match at index 2
    send_rec("cd", 1'b1, 1'b0, k0);
    sme_reply(3, 1'b1, 5'd2);
    repeat (2) @(negedge clk);
    check_burst("pat2", "cd", 1'b1, k0);
    check_res("pat2", 1, 1'b1, 5'd2, k0 + 4);
    check_err("pat2", 0, 2'd0, 0);

    // Stalled 6-char pattern still produces a contiguous burst
    send_rec("bcdefg", 1'b1, 1'b1, k0);
    #1;
    chk("stall_ready_send", 32'(in_ready), 32'd0);
    repeat (6) @(negedge clk);
    #1;
    chk("stall_ready_wait", 32'(in_ready), 32'd0);
    sme_reply(1, 1'b0, 5'd7);
    #1;
    chk("stall_ready_after", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    check_burst("stall", "bcdefg", 1'b1, k0);
    check_res("stall", 1, 1'b0, 5'd7, k0 + 8);

    // 10-byte pattern truncated to 8, overflow error then result
    send_rec("abcdefghij", 1'b1, 1'b0, k0);
    sme_reply(9, 1'b1, 5'd0);
    repeat (2) @(negedge clk);
    check_burst("patovf", "abcdefgh", 1'b1, k0);
    check_err("patovf", 1, 2'd1, k0 + 8);
    check_res("patovf", 1, 1'b1, 5'd0, k0 + 10);

    // 40-char string truncated to 32
    send_rec(s40, 1'b0, 1'b0, k0);
    repeat (34) @(negedge clk);
    check_burst("strovf", "0123456789ABCDEFGHIJKLMNOPQRSTUV", 1'b0, k0);
    check_err("strovf", 1, 2'd1, k0 + 32);
    check_res("strovf", 0, 1'b0, 5'd0, 0);

    // Timeout with TIMEOUT=16
    send_rec("bc", 1'b1, 1'b0, k0);
    repeat (17) @(negedge clk);
    #1;
    chk("tmo_ready_wait", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    chk("tmo_ready_idle", 32'(in_ready), 32'd1);
    check_burst("tmo", "bc", 1'b1, k0);
    check_err("tmo", 1, 2'd3, k0 + 18);
    check_res("tmo", 0, 1'b0, 5'd0, 0);

    // Reset mid-SEND, then pattern must see no string
    send_rec("abcdefgh", 1'b0, 1'b0, k0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chq.delete();
    check_err("midreset", 0, 2'd0, 0);
    check_res("midreset", 0, 1'b0, 5'd0, 0);
    send_rec("ab", 1'b1, 1'b0, k0);
    repeat (3) @(negedge clk);
    check_burst("nostr2", "", 1'b1, k0);
    check_err("nostr2", 1, 2'd2, k0);

    chk("both_strobes", 32'(both_high), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
